lcd_line_prefetch_sched: RTL and testbench

Schedules frame-buffer line reads ahead of the LCD timing generator so each active line is already in a ping-pong line buffer when the display starts scanning it. It issues one read request per display line to the shared memory port and steers the returned beats into the free bank. It tracks which banks are ready for display and flags underruns. It runs in the pclk domain, between the memory arbiter and the LCD driver's pixel fetch path.

---
 rtl/lcd_line_prefetch_sched.sv | 150 +++++++++++++++
 tb/tb_lcd_line_prefetch_sched.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_line_prefetch_sched.sv
// Line prefetch scheduler: issues one frame-buffer read per display line ahead of
// the LCD scan and steers the returned beats into the free half of a ping-pong buffer.
module lcd_line_prefetch_sched #(
    parameter int LINE_W = 750,
    parameter int LINES  = 1334,
    parameter int STRIDE = 1024,
    parameter int ADDR_W = 24,
    parameter int DATA_W = 24
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [ADDR_W-1:0] fb_base,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic              line_end,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [10:0]       rd_len,
    input  logic              rd_ack,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              lb_we,
    output logic [11:0]       lb_waddr,
    output logic [DATA_W-1:0] lb_wdata,
    output logic              disp_bank,
    output logic              disp_ready,
    output logic              underrun,
    output logic              busy,
    output logic [1:0]        fsm_state
);

    localparam int LW = $clog2(LINES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t            state;
    logic [LW-1:0]     fill_line;
    logic [LW-1:0]     disp_line;
    logic [1:0]        bank_valid;
    logic [ADDR_W-1:0] base_shadow;
    logic              discard;
    logic [10:0]       beat;

    logic              start_ok;
    logic              last_beat;
    logic              burst_done;
    logic              fill_done;
    logic [ADDR_W-1:0] line_off;

    // Handshake: rd_req rises with rd_addr and both hold until the cycle rd_ack is
    // high; that cycle is the transfer. Beats are then accepted on every rd_valid.
    assign line_off   = ADDR_W'(fill_line) * ADDR_W'(STRIDE);
    assign start_ok   = enable && (fill_line < LW'(LINES)) &&
                        !bank_valid[fill_line[0]] && !frame_start;
    assign last_beat  = (beat == 11'(LINE_W - 1));
    assign burst_done = (state == DATA) && rd_valid && last_beat;
    assign fill_done  = burst_done && !discard;

    assign rd_len     = 11'(LINE_W);
    assign disp_bank  = disp_line[0];
    assign disp_ready = bank_valid[disp_line[0]];
    assign busy       = (state != IDLE);
    assign fsm_state  = state;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
            lb_we       <= 1'b0;
            lb_waddr    <= '0;
            lb_wdata    <= '0;
            underrun    <= 1'b0;
            fill_line   <= '0;
            disp_line   <= '0;
            bank_valid  <= 2'b00;
            base_shadow <= '0;
            discard     <= 1'b0;
            beat        <= '0;
        end else begin
            lb_we <= 1'b0;

            if (line_start && !disp_ready) begin
                underrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state   <= REQ;
                        rd_req  <= 1'b1;
                        rd_addr <= base_shadow + line_off;
                    end
                end
                REQ: begin
                    if (rd_ack) begin
                        state  <= DATA;
                        rd_req <= 1'b0;
                        beat   <= '0;
                    end
                end
                DATA: begin
                    if (rd_valid) begin
                        // A frame_start landing on a beat already belongs to the old frame.
                        lb_we    <= !(discard || frame_start);
                        lb_waddr <= {fill_line[0], beat};
                        lb_wdata <= rd_data;
                        beat     <= beat + 11'd1;
                        if (last_beat) begin
                            state   <= IDLE;
                            discard <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    rd_req <= 1'b0;
                end
            endcase

            if (frame_start) begin
                base_shadow <= fb_base;
                disp_line   <= '0;
                fill_line   <= '0;
                bank_valid  <= 2'b00;
                if ((state != IDLE) && !burst_done) begin
                    discard <= 1'b1;
                end
            end else begin
                if (line_end) begin
                    bank_valid[disp_line[0]] <= 1'b0;
                    if (disp_line != LW'(LINES)) begin
                        disp_line <= disp_line + LW'(1);
                    end
                end
                // Placed after the line_end clear so a completing fill wins the same bank.
                if (fill_done) begin
                    bank_valid[fill_line[0]] <= 1'b1;
                    fill_line                <= fill_line + LW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_line_prefetch_sched.sv
// Directed bench for lcd_line_prefetch_sched with a small line geometry
// (4 beats per line, 3 lines, stride 16).
module tb_lcd_line_prefetch_sched;

  localparam int LINE_W = 4;
  localparam int LINES  = 3;
  localparam int STRIDE = 16;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 24;

  logic              pclk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [ADDR_W-1:0] fb_base;
  logic              frame_start;
  logic              line_start;
  logic              line_end;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [10:0]       rd_len;
  logic              rd_ack;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              lb_we;
  logic [11:0]       lb_waddr;
  logic [DATA_W-1:0] lb_wdata;
  logic              disp_bank;
  logic              disp_ready;
  logic              underrun;
  logic              busy;
  logic [1:0]        fsm_state;

  int total = 0;
  int bad   = 0;

  lcd_line_prefetch_sched #(
    .LINE_W(LINE_W), .LINES(LINES), .STRIDE(STRIDE), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .enable(enable), .fb_base(fb_base),
    .frame_start(frame_start), .line_start(line_start), .line_end(line_end),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data), .lb_we(lb_we), .lb_waddr(lb_waddr),
    .lb_wdata(lb_wdata), .disp_bank(disp_bank), .disp_ready(disp_ready),
    .underrun(underrun), .busy(busy), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // driver: wait for a request, ack after ack_delay cycles, stream LINE_W beats
  task automatic do_burst(input int ack_delay, input logic [DATA_W-1:0] dbase,
                          output int wait_steps, output logic [ADDR_W-1:0] addr,
                          output int req_cycles, output logic req_after_ack,
                          output logic [3:0] we, output logic [47:0] wa,
                          output logic [95:0] wd);
    wait_steps = 0;
    while (rd_req !== 1'b1 && wait_steps < 20) begin
      step();
      wait_steps++;
    end
    addr       = rd_addr;
    req_cycles = (rd_req === 1'b1) ? 1 : 0;
    for (int i = 0; i < ack_delay; i++) begin
      step();
      if (rd_req === 1'b1 && rd_addr === addr) req_cycles++;
    end
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    req_after_ack = rd_req;
    for (int i = 0; i < LINE_W; i++) begin
      rd_valid = 1'b1;
      rd_data  = dbase + DATA_W'(i);
      step();
      we[i]          = lb_we;
      wa[i*12 +: 12] = lb_waddr;
      wd[i*24 +: 24] = lb_wdata;
    end
    rd_valid = 1'b0;
    rd_data  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; fb_base = '0; frame_start = 1'b0;
    line_start = 1'b0; line_end = 1'b0; rd_ack = 1'b0; rd_valid = 1'b0; rd_data = '0;
    step(); step();
    total++;
    if ({rd_req, lb_we, disp_bank, disp_ready, underrun, busy} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=000000",
               {rd_req, lb_we, disp_bank, disp_ready, underrun, busy});
    end
    total++;
    if ({rd_addr, lb_waddr, lb_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_regs got addr=%h waddr=%h wdata=%h exp=0", rd_addr, lb_waddr, lb_wdata);
    end
    total++;
    if (fsm_state !== 2'd0 || rd_len !== 11'd4) begin
      bad++;
      $display("FAIL reset_state got state=%0d len=%0d exp state=0 len=4", fsm_state, rd_len);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_two_fills();
    int ws; int rc; int req_seen;
    logic [ADDR_W-1:0] a; logic ra; logic [3:0] we; logic [47:0] wa; logic [95:0] wd;
    fb_base = 24'h100; enable = 1'b1; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int f = 0; f < 2; f++) begin
      do_burst(0, 24'h10 * (f + 1), ws, a, rc, ra, we, wa, wd);
      total++;
      if (ws !== 1 || a !== 24'h100 + 24'(16 * f) || rc !== 1 || ra !== 1'b0) begin
        bad++;
        $display("FAIL fill%0d_req got wait=%0d addr=%h cycles=%0d req_after=%b exp 1/%h/1/0",
                 f, ws, a, rc, ra, 24'h100 + 24'(16 * f));
      end
      for (int i = 0; i < LINE_W; i++) begin
        total++;
        if (we[i] !== 1'b1 || wa[i*12 +: 12] !== 12'(f * 12'h800 + i) ||
            wd[i*24 +: 24] !== 24'(24'h10 * (f + 1) + i)) begin
          bad++;
          $display("FAIL fill%0d_beat%0d got we=%b waddr=%h wdata=%h exp 1/%h/%h", f, i,
                   we[i], wa[i*12 +: 12], wd[i*24 +: 24], 12'(f * 12'h800 + i),
                   24'(24'h10 * (f + 1) + i));
        end
      end
    end
    req_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rd_req === 1'b1) req_seen++;
    end
    total++;
    if (req_seen !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL no_third_req got req_cycles=%0d busy=%b exp 0/0", req_seen, busy);
    end
    total++;
    if (disp_bank !== 1'b0 || disp_ready !== 1'b1) begin
      bad++;
      $display("FAIL both_banks_ready got bank=%b ready=%b exp 0/1", disp_bank, disp_ready);
    end
  endtask

  task automatic test_line_end_refill();
    int ws; int rc; int req_seen;
    logic [ADDR_W-1:0] a; logic ra; logic [3:0] we; logic [47:0] wa; logic [95:0] wd;
    line_end = 1'b1;
    step();
    line_end = 1'b0;
    total++;
    if (disp_bank !== 1'b1 || disp_ready !== 1'b1) begin
      bad++;
      $display("FAIL line_end_disp got bank=%b ready=%b exp 1/1", disp_bank, disp_ready);
    end
    do_burst(0, 24'h30, ws, a, rc, ra, we, wa, wd);
    total++;
    if (ws !== 1 || a !== 24'h120) begin
      bad++;
      $display("FAIL refill_req got wait=%0d addr=%h exp 1/000120", ws, a);
    end
    total++;
    if (we !== 4'hf || wa !== {12'h003, 12'h002, 12'h001, 12'h000}) begin
      bad++;
      $display("FAIL refill_bank0 got we=%b waddr=%h exp 1111/003002001000", we, wa);
    end
    req_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rd_req === 1'b1) req_seen++;
    end
    total++;
    if (req_seen !== 0 || disp_ready !== 1'b1) begin
      bad++;
      $display("FAIL last_line_stop got req_cycles=%0d ready=%b exp 0/1", req_seen, disp_ready);
    end
  endtask

  task automatic test_ack_delay();
    int ws; int rc;
    logic [ADDR_W-1:0] a; logic ra; logic [3:0] we; logic [47:0] wa; logic [95:0] wd;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    do_burst(5, 24'h40, ws, a, rc, ra, we, wa, wd);
    total++;
    if (ws !== 1 || a !== 24'h100 || rc !== 6 || ra !== 1'b0) begin
      bad++;
      $display("FAIL ack_delay_hold got wait=%0d addr=%h cycles=%0d req_after=%b exp 1/000100/6/0",
               ws, a, rc, ra);
    end
    total++;
    if (we !== 4'hf || wa !== {12'h003, 12'h002, 12'h001, 12'h000} ||
        wd !== {24'h43, 24'h42, 24'h41, 24'h40}) begin
      bad++;
      $display("FAIL ack_delay_data got we=%b waddr=%h wdata=%h", we, wa, wd);
    end
    do_burst(0, 24'h50, ws, a, rc, ra, we, wa, wd);
    total++;
    if (ws !== 1 || a !== 24'h110 || wa[11:0] !== 12'h800) begin
      bad++;
      $display("FAIL ack_delay_next got wait=%0d addr=%h waddr0=%h exp 1/000110/800", ws, a, wa[11:0]);
    end
  endtask

  task automatic test_underrun();
    int n;
    total++;
    if (underrun !== 1'b0) begin
      bad++;
      $display("FAIL underrun_clear got=%b exp=0", underrun);
    end
    line_end = 1'b1;
    step();
    line_end = 1'b0;
    n = 0;
    while (rd_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    total++;
    if (rd_req !== 1'b1 || rd_addr !== 24'h120) begin
      bad++;
      $display("FAIL underrun_req got req=%b addr=%h exp 1/000120", rd_req, rd_addr);
    end
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    line_end = 1'b1;
    step();
    line_end = 1'b0;
    total++;
    if (disp_ready !== 1'b0 || disp_bank !== 1'b0) begin
      bad++;
      $display("FAIL stall_not_ready got ready=%b bank=%b exp 0/0", disp_ready, disp_bank);
    end
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    total++;
    if (underrun !== 1'b1) begin
      bad++;
      $display("FAIL underrun_set got=%b exp=1", underrun);
    end
    for (int i = 0; i < LINE_W; i++) begin
      rd_valid = 1'b1;
      rd_data  = 24'h60 + 24'(i);
      step();
    end
    rd_valid = 1'b0;
    total++;
    if (disp_ready !== 1'b1 || underrun !== 1'b1 || lb_waddr !== 12'h003) begin
      bad++;
      $display("FAIL underrun_sticky got ready=%b underrun=%b waddr=%h exp 1/1/003",
               disp_ready, underrun, lb_waddr);
    end
  endtask

  task automatic test_frame_discard();
    int n; int ws; int rc; int we_seen;
    logic [ADDR_W-1:0] a; logic ra; logic [3:0] we; logic [47:0] wa; logic [95:0] wd;
    fb_base = 24'h100; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    n = 0;
    while (rd_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    we_seen = 0;
    for (int i = 0; i < 2; i++) begin
      rd_valid = 1'b1; rd_data = 24'h80 + 24'(i);
      step();
      if (lb_we === 1'b1) we_seen++;
    end
    rd_valid = 1'b0;
    total++;
    if (we_seen !== 2) begin
      bad++;
      $display("FAIL pre_discard_beats got we_count=%0d exp=2", we_seen);
    end
    fb_base = 24'h200; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    we_seen = 0;
    for (int i = 2; i < LINE_W; i++) begin
      rd_valid = 1'b1; rd_data = 24'h80 + 24'(i);
      step();
      if (lb_we !== 1'b0) we_seen++;
    end
    rd_valid = 1'b0;
    total++;
    if (we_seen !== 0 || busy !== 1'b0 || disp_ready !== 1'b0) begin
      bad++;
      $display("FAIL discard_beats got we_count=%0d busy=%b ready=%b exp 0/0/0",
               we_seen, busy, disp_ready);
    end
    do_burst(0, 24'h70, ws, a, rc, ra, we, wa, wd);
    enable = 1'b0;
    total++;
    if (ws !== 1 || a !== 24'h200 || we !== 4'hf || wa[11:0] !== 12'h000) begin
      bad++;
      $display("FAIL post_discard_req got wait=%0d addr=%h we=%b waddr0=%h exp 1/000200/1111/000",
               ws, a, we, wa[11:0]);
    end
  endtask

  task automatic test_enable();
    int ws; int rc; int req_seen;
    logic [ADDR_W-1:0] a; logic ra; logic [3:0] we; logic [47:0] wa; logic [95:0] wd;
    fb_base = 24'h100; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    req_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rd_req === 1'b1) req_seen++;
    end
    total++;
    if (req_seen !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL enable_low_hold got req_cycles=%0d busy=%b exp 0/0", req_seen, busy);
    end
    enable = 1'b1;
    step();
    total++;
    if (rd_req !== 1'b1 || rd_addr !== 24'h100 || fsm_state !== 2'd1) begin
      bad++;
      $display("FAIL enable_req got req=%b addr=%h state=%0d exp 1/000100/1", rd_req, rd_addr, fsm_state);
    end
    do_burst(0, 24'h90, ws, a, rc, ra, we, wa, wd);
    total++;
    if (ws !== 0 || we !== 4'hf || wd[23:0] !== 24'h90) begin
      bad++;
      $display("FAIL enable_burst got wait=%0d we=%b wdata0=%h exp 0/1111/000090", ws, we, wd[23:0]);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    n = 0;
    while (rd_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    rd_valid = 1'b1; rd_data = 24'hab;
    step();
    rd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if ({rd_req, lb_we, busy, disp_ready, underrun} !== 5'b0 || rd_addr !== '0 || lb_waddr !== '0) begin
      bad++;
      $display("FAIL mid_reset got flags=%b addr=%h waddr=%h exp 0",
               {rd_req, lb_we, busy, disp_ready, underrun}, rd_addr, lb_waddr);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_two_fills();
    test_line_end_refill();
    test_ack_delay();
    test_underrun();
    test_frame_discard();
    test_enable();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
